// File: rtl/fp32_norm_encoder_arbiter.sv
// Round-robin arbiter sharing one leading-one normalization encoder among NUM_REQ lanes.
// Define ENC_ARB_PERF_EN to add saturating issue/stall performance counters.
module fp32_norm_encoder_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 49,
    parameter int unsigned CODE_W  = 8,
    parameter int unsigned ENC_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      enc_valid_in,
    output logic [DATA_W-1:0]         enc_data,
    input  logic                      enc_valid_out,
    input  logic [CODE_W-1:0]         enc_code,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*CODE_W-1:0] rsp_code,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      err
`ifdef ENC_ARB_PERF_EN
    ,
    output logic [15:0]               perf_issue_cnt,
    output logic [15:0]               perf_stall_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TAG_W = IDX_W + 1;

    typedef enum logic [1:0] {StIdle, StIssued, StResp} lane_state_e;

    lane_state_e       state_q [NUM_REQ];
    logic [CODE_W-1:0] code_q  [NUM_REQ];
    logic [IDX_W-1:0]  ptr_q;
    logic              enc_valid_q;
    logic [DATA_W-1:0] enc_data_q;
    logic [TAG_W-1:0]  iss_tag_q;
    logic [TAG_W-1:0]  tag_pipe_q [ENC_LAT];
    logic              err_q;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_idx;
    int unsigned        cand;
    logic               head_vld;
    logic [IDX_W-1:0]   head_idx;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (state_q[i] == StIdle);
        end
    end

    // Search starts one past the last winner so every lane gets a turn.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!gnt_any && elig[IDX_W'(cand)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_any) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = rstn ? gnt_oh : '0;

    // The issue-stage tag rides with enc_valid_in; the ENC_LAT stages behind it line up
    // the head with the encoder's result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            enc_valid_q <= 1'b0;
            enc_data_q  <= '0;
            iss_tag_q   <= '0;
            for (int i = 0; i < ENC_LAT; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            enc_valid_q <= gnt_any;
            iss_tag_q   <= {gnt_any, gnt_idx};
            if (gnt_any) begin
                ptr_q      <= gnt_idx;
                enc_data_q <= req_data[32'(gnt_idx)*DATA_W +: DATA_W];
            end
            tag_pipe_q[0] <= iss_tag_q;
            for (int i = 1; i < ENC_LAT; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
        end
    end

    assign head_vld = tag_pipe_q[ENC_LAT-1][IDX_W];
    assign head_idx = tag_pipe_q[ENC_LAT-1][IDX_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= StIdle;
                code_q[i]  <= '0;
            end
        end else begin
            // Result without a tag, or a tag without a result.
            if (enc_valid_out != head_vld) begin
                err_q <= 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                unique case (state_q[i])
                    StIdle: begin
                        if (gnt_oh[i]) state_q[i] <= StIssued;
                    end
                    StIssued: begin
                        if (head_vld && head_idx == IDX_W'(i)) begin
                            if (enc_valid_out) begin
                                state_q[i] <= StResp;
                                code_q[i]  <= enc_code;
                            end else begin
                                state_q[i] <= StIdle;
                            end
                        end
                    end
                    StResp: begin
                        if (rsp_ready[i]) state_q[i] <= StIdle;
                    end
                    default: state_q[i] <= StIdle;
                endcase
            end
        end
    end

    assign enc_valid_in = enc_valid_q;
    assign enc_data     = enc_data_q;
    assign err          = err_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
        assign rsp_valid[i]                  = (state_q[i] == StResp);
        assign rsp_code[i*CODE_W +: CODE_W] = code_q[i];
    end

`ifdef ENC_ARB_PERF_EN
    logic [15:0] issue_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (gnt_any && issue_cnt_q != 16'hFFFF) begin
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            if (|(elig & ~gnt_oh) && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fp32_norm_encoder_arbiter.sv
// Self-checking bench: transaction-level model plus directed vectors with literal expectations.
// Exercises the ENC_ARB_PERF_EN counters when that macro is defined.
module tb_fp32_norm_encoder_arbiter;

    localparam int NR = 4;
    localparam int DW = 49;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_data = '0;
    logic              enc_valid_in;
    logic [DW-1:0]     enc_data;
    logic              enc_valid_out;
    logic [CW-1:0]     enc_code;
    logic [NR-1:0]     rsp_valid;
    logic [NR*CW-1:0]  rsp_code;
    logic [NR-1:0]     rsp_ready = '1;
    logic              err;
`ifdef ENC_ARB_PERF_EN
    logic [15:0]       perf_issue_cnt;
    logic [15:0]       perf_stall_cnt;
`endif

    logic inj_sp = 1'b0;
    logic inj_drop = 1'b0;
    logic chk_on = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    fp32_norm_encoder_arbiter dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .enc_valid_in  (enc_valid_in),
        .enc_data      (enc_data),
        .enc_valid_out (enc_valid_out),
        .enc_code      (enc_code),
        .rsp_valid     (rsp_valid),
        .rsp_code      (rsp_code),
        .rsp_ready     (rsp_ready),
        .err           (err)
`ifdef ENC_ARB_PERF_EN
        ,
        .perf_issue_cnt(perf_issue_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    // Leading-one code: single bit k<48 -> 47-k, bit 48 -> 0x80, otherwise 0x40.
    function automatic logic [7:0] enc_f(input logic [48:0] d);
        if ($countones(d) != 1) return 8'h40;
        if (d[48]) return 8'h80;
        for (int k = 0; k < 48; k++) if (d[k]) return 8'(47 - k);
        return 8'h40;
    endfunction

    // Encoder stand-in with one cycle of latency; fault injection on its valid.
    logic       enc_vo;
    logic [7:0] enc_cd;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            enc_vo <= 1'b0;
            enc_cd <= '0;
        end else begin
            enc_vo <= enc_valid_in;
            enc_cd <= enc_f(enc_data);
        end
    end
    assign enc_valid_out = (enc_vo & ~inj_drop) | inj_sp;
    assign enc_code      = enc_cd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: lane phase 0 idle / 1 waiting / 2 holding a response.
    typedef struct {
        int          lane;
        logic [48:0] d;
        int          due;
    } txn_t;

    txn_t        m_q[$];
    txn_t        t;
    int          m_ph[NR];
    logic [7:0]  m_code[NR];
    int          m_ptr = NR - 1;
    logic        m_iv = 1'b0;
    logic [48:0] m_id = '0;
    logic        m_err = 1'b0;
    int          cyc = 0;
    int          g;

    function automatic int pick();
        if (!rstn) return -1;
        for (int k = 1; k <= NR; k++) begin
            int l;
            l = (m_ptr + k) % NR;
            if (req_valid[l] && m_ph[l] == 0) return l;
        end
        return -1;
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_ph[i] = 0;
            m_code[i] = '0;
        end
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_q.delete();
                m_ptr = NR - 1;
                m_iv = 1'b0;
                m_id = '0;
                m_err = 1'b0;
                for (int i = 0; i < NR; i++) begin
                    m_ph[i] = 0;
                    m_code[i] = '0;
                end
            end else begin
                g = pick();
                for (int i = 0; i < NR; i++) if (m_ph[i] == 2 && rsp_ready[i]) m_ph[i] = 0;
                if (m_q.size() > 0 && m_q[0].due == cyc) begin
                    t = m_q.pop_front();
                    if (inj_drop) begin
                        m_ph[t.lane] = 0;
                        m_err = 1'b1;
                    end else begin
                        m_ph[t.lane] = 2;
                        m_code[t.lane] = enc_f(t.d);
                    end
                end else if (inj_sp) begin
                    m_err = 1'b1;
                end
                if (g >= 0) begin
                    m_ph[g] = 1;
                    m_q.push_back('{g, req_data[g*DW +: DW], cyc + 2});
                    m_ptr = g;
                    m_iv = 1'b1;
                    m_id = req_data[g*DW +: DW];
                end else begin
                    m_iv = 1'b0;
                end
                cyc++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            int            gg;
            logic [NR-1:0] er;
            logic [NR-1:0] erv;
            logic [NR*CW-1:0] ec;
            gg = pick();
            er = (gg >= 0) ? NR'(1 << gg) : '0;
            for (int i = 0; i < NR; i++) begin
                erv[i] = (m_ph[i] == 2);
                ec[i*CW +: CW] = m_code[i];
            end
            chk("cmp_req_ready", 64'(req_ready), 64'(er));
            chk("cmp_enc_valid_in", 64'(enc_valid_in), 64'(m_iv));
            chk("cmp_enc_data", 64'(enc_data), 64'(m_id));
            chk("cmp_rsp_valid", 64'(rsp_valid), 64'(erv));
            chk("cmp_rsp_code", 64'(rsp_code), 64'(ec));
            chk("cmp_err", 64'(err), 64'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        inj_sp = 1'b0;
        inj_drop = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic set_data(input int l, input logic [48:0] v);
        req_data[l*DW +: DW] = v;
    endtask

    int exp4[12] = '{1, 4, 0, 0, 1, 4, 0, 0, 1, 4, 0, 0};
    int g_oth;

    initial begin
        do_reset();
        chk_on = 1'b1;

        // 1: single lane, bit 48 set -> right-shift code, latency 3.
        tick(); set_data(0, 49'h1_0000_0000_0000); req_valid = 4'b0001;
        @(negedge clk); chk("t1_ready_c0", 64'(req_ready), 64'h1);
        tick(); req_valid = '0;
        @(negedge clk); chk("t1_issue_c1", 64'(enc_valid_in), 64'h1);
        chk("t1_data_c1", 64'(enc_data), 64'h1_0000_0000_0000);
        tick(); @(negedge clk); chk("t1_rsp_c2", 64'(rsp_valid), 64'h0);
        tick(); @(negedge clk); chk("t1_rsp_c3", 64'(rsp_valid), 64'h1);
        chk("t1_code_c3", 64'(rsp_code[7:0]), 64'h80);

        // 2: all four lanes at once, served in lane order.
        do_reset();
        tick();
        for (int l = 0; l < NR; l++) set_data(l, 49'(1) << l);
        req_valid = '1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("t2_ready", 64'(req_ready), (k < 4) ? 64'(1) << k : 64'h0);
            if (k >= 3) begin
                chk("t2_rsp_valid", 64'(rsp_valid), 64'(1) << (k - 3));
                chk("t2_code", 64'(rsp_code[(k-3)*CW +: CW]), 64'(47 - (k - 3)));
            end
`ifdef ENC_ARB_PERF_EN
            if (k == 6) begin
                chk("t2_issue_cnt", 64'(perf_issue_cnt), 64'd4);
                chk("t2_stall_cnt", 64'(perf_stall_cnt), 64'd3);
            end
`endif
            tick();
            if (k < 4) req_valid[k] = 1'b0;
        end

        // 3: lane 1 back-pressured while the others keep flowing.
        do_reset();
        tick();
        set_data(0, 49'h10); set_data(1, 49'h100); set_data(2, 49'h3);
        set_data(3, 49'h8000_0000_0000);
        req_valid = '1; rsp_ready = 4'b1101;
        g_oth = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                chk("t3_ready1_blocked", 64'(req_ready[1]), 64'h0);
                chk("t3_rsp1_held", 64'(rsp_valid[1]), 64'h1);
                chk("t3_code1_held", 64'(rsp_code[15:8]), 64'd39);
                if ((req_ready & 4'b1101) != 0) g_oth++;
            end
            tick();
        end
        rsp_ready = '1;
        @(negedge clk);
        chk("t3_others_served", 64'(g_oth >= 3), 64'h1);
        chk("t3_ready1_hs_cycle", 64'(req_ready[1]), 64'h0);
        tick(); @(negedge clk);
        chk("t3_rsp1_cleared", 64'(rsp_valid[1]), 64'h0);
        req_valid = '0;
        repeat (5) tick();

        // 4: lanes 0 and 2 continuous -> 0,2 alternate, never while busy.
        do_reset();
        tick();
        set_data(0, 49'h1); set_data(2, 49'h4_0000);
        req_valid = 4'b0101;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t4_ready_seq", 64'(req_ready), 64'(exp4[k]));
            tick();
        end
        req_valid = '0;
        repeat (4) tick();

        // 5: zero and two-bit operands -> 0x40, no error.
        do_reset();
        tick(); set_data(0, 49'h0); set_data(1, 49'h3); req_valid = 4'b0011;
        tick(); req_valid = 4'b0010;
        tick(); req_valid = '0;
        tick(); @(negedge clk);
        chk("t5_code_zero", 64'(rsp_code[7:0]), 64'h40);
        tick(); @(negedge clk);
        chk("t5_code_two", 64'(rsp_code[15:8]), 64'h40);
        chk("t5_err", 64'(err), 64'h0);

        // 6: reset while lane 3 is in flight.
        do_reset();
        tick(); set_data(3, 49'h1_0000_0000); req_valid = 4'b1000;
        tick(); req_valid = '0;
        tick(); rstn = 1'b0; #1;
        chk("t6_rst_ready", 64'(req_ready), 64'h0);
        chk("t6_rst_vin", 64'(enc_valid_in), 64'h0);
        chk("t6_rst_data", 64'(enc_data), 64'h0);
        chk("t6_rst_rsp", 64'(rsp_valid), 64'h0);
        chk("t6_rst_err", 64'(err), 64'h0);
        #1 rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("t6_no_stale_rsp", 64'(rsp_valid[3]), 64'h0);
            tick();
        end
        set_data(3, 49'h10_0000); req_valid = 4'b1000;
        @(negedge clk); chk("t6_new_ready", 64'(req_ready), 64'h8);
        tick(); req_valid = '0;
        tick(); tick(); @(negedge clk);
        chk("t6_new_rsp", 64'(rsp_valid), 64'h8);
        chk("t6_new_code", 64'(rsp_code[31:24]), 64'd27);

        // 7a: encoder result with no outstanding tag.
        do_reset();
        tick(); inj_sp = 1'b1;
        tick(); inj_sp = 1'b0;
        @(negedge clk); chk("t7_spurious_err", 64'(err), 64'h1);
        tick(); @(negedge clk); chk("t7_err_sticky", 64'(err), 64'h1);

        // 7b: missing encoder result -> lane freed, no response, error.
        do_reset();
        @(negedge clk); chk("t7_err_reset", 64'(err), 64'h0);
        tick(); set_data(2, 49'h5); req_valid = 4'b0100;
        tick();
        tick(); inj_drop = 1'b1;
        tick(); inj_drop = 1'b0;
        @(negedge clk);
        chk("t7_drop_no_rsp", 64'(rsp_valid), 64'h0);
        chk("t7_drop_err", 64'(err), 64'h1);
        chk("t7_drop_regrant", 64'(req_ready), 64'h4);
        tick(); req_valid = '0;
        tick(); tick(); @(negedge clk);
        chk("t7_retry_code", 64'(rsp_code[23:16]), 64'h40);
        repeat (3) tick();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
